// File: rtl/banco_reg_multi_pkg.sv
// rtl/banco_reg_multi_pkg.sv - shared constants and clear FSM state type for banco_reg_multi
package banco_reg_multi_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_t;

endpackage

// File: rtl/banco_reg_clear_fsm.sv
// rtl/banco_reg_clear_fsm.sv - bulk clear sequencer: walks every register index once, then pulses done
module banco_reg_clear_fsm
   import banco_reg_multi_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear_req,
   output logic              o_clr_en,
   output logic [ADDR_W-1:0] o_clr_addr,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

   clr_state_t        r_state;
   clr_state_t        w_next;
   logic [ADDR_W-1:0] r_idx;

   // The index saturates at the last register; it is reloaded on the next clear request.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && i_clear_req)
            r_idx <= '0;
         else if (r_state == CLEAR && r_idx != LAST_IDX)
            r_idx <= r_idx + ADDR_W'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_clear_req) w_next = CLEAR;
         CLEAR:   if (r_idx == LAST_IDX) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_clr_en   = (r_state == CLEAR);
      o_clr_addr = r_idx;
      o_busy     = (r_state != IDLE);
      o_done     = (r_state == DONE);
   end

endmodule

// File: rtl/banco_reg_multi.sv
// rtl/banco_reg_multi.sv - multi-read-port register file with bulk clear
// Optional write-through forwarding on read ports: BANCO_REG_BYPASS_EN.
module banco_reg_multi
   import banco_reg_multi_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int N_READ = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     reg_write,
   input  logic [ADDR_W-1:0]        reg_escrita,
   input  logic [DATA_W-1:0]        escreve_dado,
   input  logic [N_READ*ADDR_W-1:0] reg_leitura,
   output logic [N_READ*DATA_W-1:0] dado,
   input  logic                     clear_req,
   output logic                     clear_busy,
   output logic                     clear_done
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic              w_clr_en;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_wr_en;

   banco_reg_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .i_clk       (clock),
      .i_rst       (reset),
      .i_clear_req (clear_req),
      .o_clr_en    (w_clr_en),
      .o_clr_addr  (w_clr_addr),
      .o_busy      (clear_busy),
      .o_done      (clear_done)
   );

   assign w_wr_en = reg_write && !clear_busy && (reg_escrita != '0);

   // Writes are blocked by clear_busy, so the clear and write paths never collide.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_regs[i] <= '0;
      end else if (w_clr_en) begin
         r_regs[w_clr_addr] <= '0;
      end else if (w_wr_en) begin
         r_regs[reg_escrita] <= escreve_dado;
      end
   end

   for (genvar k = 0; k < N_READ; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_stored;

      assign w_addr   = reg_leitura[k*ADDR_W +: ADDR_W];
      assign w_stored = (w_addr == '0) ? '0 : r_regs[w_addr];
`ifdef BANCO_REG_BYPASS_EN
      assign dado[k*DATA_W +: DATA_W] = (w_wr_en && w_addr == reg_escrita) ? escreve_dado : w_stored;
`else
      assign dado[k*DATA_W +: DATA_W] = w_stored;
`endif
   end

endmodule

// File: tb/tb_banco_reg_multi.sv
// tb/tb_banco_reg_multi.sv - scoreboard bench for banco_reg_multi (default and 4-port narrow instances)
module tb_banco_reg_multi;

`ifdef BANCO_REG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int K_P0 = 0, K_P1 = 1, K_BUSY = 2, K_DONE = 3, K_Q0 = 4;

   typedef struct packed {
      logic [3:0]  kind;
      logic [31:0] val;
      logic [15:0] step;
   } chk_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr, creq;
   logic [5:0]  wa;
   logic [31:0] wd;
   logic [11:0] ra;
   logic [63:0] dout;
   logic        busy, done;

   logic        wr4;
   logic        creq4;
   logic [3:0]  wa4;
   logic [15:0] wd4;
   logic [15:0] ra4;
   logic [63:0] dout4;
   logic        busy4, done4;

   chk_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   step     = 0;

   always #5 clk = ~clk;

   banco_reg_multi dut (
      .clock        (clk),
      .reset        (rst),
      .reg_write    (wr),
      .reg_escrita  (wa),
      .escreve_dado (wd),
      .reg_leitura  (ra),
      .dado         (dout),
      .clear_req    (creq),
      .clear_busy   (busy),
      .clear_done   (done)
   );

   banco_reg_multi #(
      .DATA_W (16),
      .ADDR_W (4),
      .N_READ (4)
   ) dut4 (
      .clock        (clk),
      .reset        (rst),
      .reg_write    (wr4),
      .reg_escrita  (wa4),
      .escreve_dado (wd4),
      .reg_leitura  (ra4),
      .dado         (dout4),
      .clear_req    (creq4),
      .clear_busy   (busy4),
      .clear_done   (done4)
   );

   function automatic logic [31:0] actual(input logic [3:0] k);
      case (k)
         4'd0:    return dout[31:0];
         4'd1:    return dout[63:32];
         4'd2:    return {31'b0, busy};
         4'd3:    return {31'b0, done};
         4'd4:    return {16'b0, dout4[15:0]};
         4'd5:    return {16'b0, dout4[31:16]};
         4'd6:    return {16'b0, dout4[47:32]};
         4'd7:    return {16'b0, dout4[63:48]};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic push(input int k, input logic [31:0] v);
      chk_t c;
      c.kind = 4'(k);
      c.val  = v;
      c.step = 16'(step);
      step++;
      sb.push_back(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every queued expectation mid-cycle
   initial begin
      chk_t c;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            c = sb.pop_front();
            a = actual(c.kind);
            n_checks++;
            if (a !== c.val) begin
               n_fail++;
               $display("FAIL chk kind=%0d step=%0d: actual=%0h required=%0h", c.kind, c.step, a, c.val);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; wr = 0; wa = 0; wd = 0; ra = 0; creq = 0;
      wr4 = 0; wa4 = 0; wd4 = 0; ra4 = 0; creq4 = 0;

      // reset state
      tick();
      ra = {6'd0, 6'd5};
      push(K_BUSY, 0); push(K_DONE, 0); push(K_P0, 0); push(K_P1, 0);

      // first write on the first edge after reset release
      tick();
      rst = 1'b0; wr = 1; wa = 6'd3; wd = 32'h0BAD_F00D;
      push(K_BUSY, 0);
      tick();
      wr = 0; ra = {6'd0, 6'd3};
      push(K_P0, 32'h0BAD_F00D); push(K_P1, 0);

      // write 5, read port0 @5, port1 @0
      tick();
      wr = 1; wa = 6'd5; wd = 32'hDEAD_BEEF; ra = {6'd0, 6'd5};
      push(K_P0, BYP ? 32'hDEAD_BEEF : 32'h0);
      tick();
      wr = 0;
      push(K_P0, 32'hDEAD_BEEF); push(K_P1, 0);

      // write to register 0 is discarded
      tick();
      wr = 1; wa = 6'd0; wd = 32'h1234_5678; ra = 12'd0;
      push(K_P0, 0); push(K_P1, 0);
      tick();
      wr = 0;
      push(K_P0, 0);

      // same-cycle read of the register being written
      tick();
      wr = 1; wa = 6'd7; wd = 32'h1111_1111;
      tick();
      wd = 32'hA5A5_A5A5; ra = {6'd7, 6'd7};
      push(K_P0, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
      push(K_P1, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
      tick();
      wr = 0;
      push(K_P0, 32'hA5A5_A5A5);

      // four ports on the narrow instance
      tick(); wr4 = 1; wa4 = 4'd1;  wd4 = 16'h1111;
      tick(); wa4 = 4'd2;  wd4 = 16'h2222;
      tick(); wa4 = 4'd9;  wd4 = 16'h9999;
      tick(); wa4 = 4'd15; wd4 = 16'hFFFF;
      tick(); wr4 = 0; ra4 = {4'd15, 4'd9, 4'd2, 4'd1};
      push(K_Q0, 16'h1111); push(K_Q0 + 1, 16'h2222); push(K_Q0 + 2, 16'h9999); push(K_Q0 + 3, 16'hFFFF);
      tick(); ra4 = {4'd1, 4'd0, 4'd15, 4'd9};
      push(K_Q0, 16'h9999); push(K_Q0 + 1, 16'hFFFF); push(K_Q0 + 2, 16'h0); push(K_Q0 + 3, 16'h1111);

      // fill regs 1..63 with their index and read them back
      for (int a = 1; a < 64; a++) begin
         tick(); wr = 1; wa = 6'(a); wd = 32'(a);
      end
      tick(); wr = 0;
      for (int a = 0; a < 64; a++) begin
         ra = {6'(63 - a), 6'(a)};
         push(K_P0, 32'(a)); push(K_P1, 32'(63 - a));
         tick();
      end

      // bulk clear with dropped writes and ignored requests
      creq = 1;
      push(K_BUSY, 0); push(K_DONE, 0);
      tick();
      creq = 0;
      for (int i = 0; i <= 64; i++) begin
         wr   = (i == 40 || i == 64);
         wa   = (i == 64) ? 6'd6 : 6'd5;
         wd   = 32'hBAD0_0000;
         creq = (i == 30 || i == 64);
         push(K_BUSY, 1); push(K_DONE, (i == 64) ? 32'd1 : 32'd0);
         tick();
      end
      wr = 0; creq = 0;
      push(K_BUSY, 0); push(K_DONE, 0);
      for (int a = 0; a < 64; a++) begin
         ra = {6'(63 - a), 6'(a)};
         push(K_P0, 0); push(K_P1, 0);
         tick();
      end

      // simultaneous write and clear request in IDLE
      wr = 1; wa = 6'd12; wd = 32'h0000_C0C0; creq = 1; ra = {6'd0, 6'd12};
      push(K_BUSY, 0);
      tick();
      wr = 0; creq = 0;
      push(K_P0, 32'h0000_C0C0); push(K_BUSY, 1);
      for (int i = 0; i < 65; i++) tick();
      push(K_BUSY, 0); push(K_P0, 0);

      // reset asserted in the middle of a clear
      tick(); wr = 1; wa = 6'd3;  wd = 32'h33;
      tick(); wa = 6'd50; wd = 32'h50;
      tick(); wr = 0; ra = {6'd50, 6'd3};
      push(K_P0, 32'h33); push(K_P1, 32'h50);
      creq = 1;
      tick();
      creq = 0;
      for (int i = 0; i < 10; i++) tick();
      push(K_BUSY, 1); push(K_P1, 32'h50);
      tick();
      rst = 1'b1;
      push(K_BUSY, 0); push(K_DONE, 0); push(K_P0, 0); push(K_P1, 0);
      tick();
      push(K_BUSY, 0);
      tick();
      rst = 1'b0; wr = 1; wa = 6'd3; wd = 32'h3C3C_3C3C;
      push(K_BUSY, 0); push(K_DONE, 0);
      tick();
      wr = 0;
      push(K_P0, 32'h3C3C_3C3C); push(K_P1, 0); push(K_BUSY, 0);
      for (int i = 0; i < 70; i++) begin
         push(K_DONE, 0); push(K_BUSY, 0);
         tick();
      end

      tick();
      tick();
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: actual=%0d pending, required=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/banco_reg_multi.md
BANCO_REG_MULTI -- requirements
Module: banco_reg_multi

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 6: address width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter N_READ, default 2: number of independent read ports, valid range 1..4.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 reg_write  input  1  write enable for the write port.
REQ-007 reg_escrita  input  ADDR_W  write address.
REQ-008 escreve_dado  input  DATA_W  write data.
REQ-009 reg_leitura  input  N_READ*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-010 dado  output  N_READ*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-011 clear_req  input  1  one-cycle request to start a bulk clear of all registers.
REQ-012 clear_busy  output  1  high while the bulk clear is in progress.
REQ-013 clear_done  output  1  one-cycle pulse when the bulk clear completes.

Function
REQ-014 A write SHALL occur on the rising edge when reg_write=1, clear_busy=0 and reg_escrita!=0.
REQ-015 Register 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-016 Each read port SHALL be combinational: dado[k] = contents of the register at reg_leitura[k], with zero latency.
REQ-017 The clear FSM SHALL have states IDLE, CLEAR and DONE.
REQ-018 IDLE -> CLEAR when clear_req=1; the index counter SHALL load 0.
REQ-019 In CLEAR, register[index] SHALL be zeroed each cycle and index incremented; when index=DEPTH-1, the register SHALL be zeroed and the next state SHALL be DONE.
REQ-020 A full clear SHALL take exactly DEPTH cycles in CLEAR.
REQ-021 DONE SHALL last one cycle with clear_done=1, then return to IDLE.
REQ-022 clear_busy SHALL be 1 in CLEAR and DONE, and 0 in IDLE.
REQ-023 A write while clear_busy=1 SHALL be dropped; no queuing.
REQ-024 clear_req in CLEAR or DONE SHALL be ignored.
REQ-025 Simultaneous clear_req and reg_write in IDLE: the write SHALL take effect on that edge and the FSM SHALL enter CLEAR; the clear subsequently zeroes the written register.
REQ-026 The index counter SHALL NOT wrap; it stops at DEPTH-1.

Reset
REQ-027 reset=1 SHALL immediately set all registers to 0, FSM to IDLE, index to 0, clear_busy=0 and clear_done=0, independent of the clock.
REQ-028 Reset asserted during CLEAR SHALL abort the clear; after release the FSM SHALL be in IDLE with no clear_done pulse.
REQ-029 The first write SHALL be accepted on the first rising edge after reset deassertion.

Configuration
REQ-030 Macro BANCO_REG_BYPASS_EN: when defined, a read port whose address equals reg_escrita (nonzero) while reg_write=1 and clear_busy=0 SHALL return escreve_dado combinationally (write-through).
REQ-031 When BANCO_REG_BYPASS_EN is undefined, reads SHALL return the stored value only; new data is visible after the write edge.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, CLEAR, DONE) and the default DATA_W/ADDR_W constants.
REQ-033 One sub-module, banco_reg_clear_fsm, SHALL contain the clear FSM and index counter; it drives the clear address/enable to the top-level array.

Verification
REQ-034 Write 0xDEADBEEF to reg 5, then read port 0 at address 5 -> 0xDEADBEEF after the edge; port 1 at address 0 -> 0.
REQ-035 Write 0x12345678 to reg 0 -> a read of address 0 remains 0.
REQ-036 Fill regs 1..63 with their index, then pulse clear_req -> clear_busy high for 65 cycles, clear_done pulses exactly once, all regs read 0; writes issued during busy are dropped.
REQ-037 Assert reset at cycle 10 of a clear -> outputs 0 asynchronously, FSM in IDLE, no clear_done pulse; a subsequent write to reg 3 succeeds.
REQ-038 With BANCO_REG_BYPASS_EN defined, write 0xA5A5A5A5 to reg 7 while reading address 7 -> same-cycle dado=0xA5A5A5A5; without the macro -> the old value until the edge.
REQ-039 N_READ=4, ADDR_W=4, DATA_W=16: four ports read four distinct registers simultaneously -> each returns the correct value.
